// File: rtl/splitter_serializer.sv
// Splits a 32-bit word into 1..4 bytes, MSB first, optionally bit-reversed; byte 0 valid one cycle after accept.
// Holds the current byte under out_ready=0; in_ready in SEND follows out_ready & out_last combinationally.
module splitter_serializer #(
    parameter bit ZERO_IDLE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [1:0]  in_len,
    input  logic        in_rev,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [1:0]  out_idx,
    output logic        out_last,
    output logic        word_done
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SEND = 1'b1;

    logic        state;
    logic [31:0] word;
    logic [1:0]  len;
    logic        rev;
    logic [1:0]  idx;
    logic [7:0]  held_byte;

    logic [7:0]  raw_byte;
    logic [7:0]  send_byte;
    logic        sending;
    logic        in_hs;
    logic        out_hs;

    assign sending = (state == ST_SEND);

    always_comb begin
        raw_byte = 8'h00;
        case (idx)
            2'd0:    raw_byte = word[31:24];
            2'd1:    raw_byte = word[23:16];
            2'd2:    raw_byte = word[15:8];
            default: raw_byte = word[7:0];
        endcase
    end

    // Reversed form mirrors the splitter lane mapping: out[7] takes the byte's lowest bit.
    always_comb begin
        send_byte = raw_byte;
        if (rev) begin
            for (int j = 0; j < 8; j++) begin
                send_byte[7-j] = raw_byte[j];
            end
        end
    end

    assign out_valid = sending;
    assign out_idx   = sending ? idx : 2'd0;
    assign out_last  = sending && (idx == len);
    assign out_data  = sending   ? send_byte :
                       ZERO_IDLE ? 8'h00     : held_byte;
    assign in_ready  = !sending || (out_ready && out_last);

    assign out_hs = sending && out_ready;
    assign in_hs  = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            word      <= 32'h0;
            len       <= 2'd0;
            rev       <= 1'b0;
            idx       <= 2'd0;
            held_byte <= 8'h00;
            word_done <= 1'b0;
        end else begin
            word_done <= out_hs && out_last;
            if (out_hs) begin
                held_byte <= send_byte;
            end
            // A new word can only be accepted in SEND on the final byte's handshake.
            if (in_hs) begin
                word  <= in_data;
                len   <= in_len;
                rev   <= in_rev;
                idx   <= 2'd0;
                state <= ST_SEND;
            end else if (out_hs) begin
                if (out_last) begin
                    state <= ST_IDLE;
                end else begin
                    idx <= idx + 2'd1;
                end
            end
        end
    end

endmodule
